// File: rtl/uart_rx_framer_pkg.sv
// Shared constants and types for the UART receive path (also intended for the transmitter).
package uart_rx_framer_pkg;

  // 8N1 framing
  localparam int unsigned DataBits = 8;
  localparam int unsigned IdxW     = $clog2(DataBits);

  // 50 MHz / 115200 baud
  localparam int unsigned DefaultClksPerBit = 434;
  localparam int unsigned DefaultSyncStages = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

endpackage

// File: rtl/uart_rx_framer_if.sv
// Received-byte handshake and diagnostic pulses between framer and consumer.
interface uart_rx_framer_if;

  logic [uart_rx_framer_pkg::DataBits-1:0] data;
  logic                                    data_valid;
  logic                                    data_ack;
  logic                                    frame_error;
  logic                                    overrun;
  logic                                    busy;

  modport master (
    output data,
    output data_valid,
    output frame_error,
    output overrun,
    output busy,
    input  data_ack
  );

  modport slave (
    input  data,
    input  data_valid,
    input  frame_error,
    input  overrun,
    input  busy,
    output data_ack
  );

endinterface

// File: rtl/uart_rx_framer_sync_ff.sv
// N-stage synchronizer for asynchronous inputs; resets to 1 (idle level of UART lines/buttons).
module uart_rx_framer_sync_ff #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: mid-bit sampling FSM, shift register and single-entry holding register.
module uart_rx_framer
  import uart_rx_framer_pkg::*;
#(
  parameter int unsigned ClksPerBit = DefaultClksPerBit,
  parameter int unsigned SyncStages = DefaultSyncStages
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             rx_i,
  uart_rx_framer_if.master byte_if
);

  localparam int unsigned       CntW     = $clog2(ClksPerBit);
  localparam logic [CntW-1:0]   HalfLoad = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0]   BitLoad  = CntW'(ClksPerBit - 1);
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(DataBits - 1);

  logic rx_s;

  rx_state_e             state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DataBits-1:0]   shift_q, shift_d;
  logic [DataBits-1:0]   data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  byte_done;

  uart_rx_framer_sync_ff #(
    .Stages (SyncStages)
  ) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (rx_i),
    .q_o     (rx_s)
  );

  // Frame FSM: start detection, mid-bit sampling, stop check and break hold-off.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            idx_d   = '0;
            cnt_d   = BitLoad;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = BitLoad;
          if (idx_q == LastIdx) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          // Leave at mid-stop-bit so a back-to-back start edge is not missed.
          state_d = rx_s ? StIdle : StBreak;
          byte_done = rx_s;
          ferr_d    = !rx_s;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StBreak: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Holding register: a completing byte loads unless the previous one is still unread.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (byte_done) begin
      if (!valid_q || byte_if.data_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (byte_if.data_ack && valid_q) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign byte_if.data        = data_q;
  assign byte_if.data_valid  = valid_q;
  assign byte_if.frame_error = ferr_q;
  assign byte_if.overrun     = ovr_q;
  assign byte_if.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer at 16 clocks per bit, 2 sync stages.
module tb_uart_rx_framer;

  localparam int unsigned Cpb = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic vprev = 1'b0;

  uart_rx_framer_if byte_if ();

  uart_rx_framer #(
    .ClksPerBit (Cpb),
    .SyncStages (2)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .rx_i    (rx),
    .byte_if (byte_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and DataValid rise time, sampled mid-cycle.
  always @(negedge clk) begin
    if (byte_if.data_valid && !vprev) rise_cyc <= cyc;
    vprev  <= byte_if.data_valid;
    fe_cnt <= fe_cnt + int'(byte_if.frame_error);
    ov_cnt <= ov_cnt + int'(byte_if.overrun);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one 10-bit frame (160 cycles); DataAck is high only in frame cycle ack_at.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at,
                            output int n0);
    n0 = cyc;
    for (int k = 0; k < 10 * Cpb; k++) begin
      int bit_no;
      bit_no = k / Cpb;
      if (bit_no == 0) rx = 1'b0;
      else if (bit_no == 9) rx = stop;
      else rx = b[bit_no-1];
      byte_if.data_ack = (k == ack_at);
      tick();
    end
    byte_if.data_ack = 1'b0;
    rx = 1'b1;
  endtask

  task automatic ack_byte();
    byte_if.data_ack = 1'b1;
    tick();
    byte_if.data_ack = 1'b0;
  endtask

  initial begin
    int n0;
    int fe0;
    int ov0;
    byte_if.data_ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_data", 32'(byte_if.data), 32'h00);
    check("reset_valid", 32'(byte_if.data_valid), 32'h0);
    check("reset_ferr", 32'(byte_if.frame_error), 32'h0);
    check("reset_ovr", 32'(byte_if.overrun), 32'h0);
    check("reset_busy", 32'(byte_if.busy), 32'h0);
    tick();

    // 0x41, no ack
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h41, 1'b1, -1, n0);
    check("x41_latency", 32'(rise_cyc - n0), 32'd155);
    check("x41_data", 32'(byte_if.data), 32'h41);
    check("x41_valid", 32'(byte_if.data_valid), 32'h1);
    check("x41_no_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    ack_byte();
    check("ack_clears_valid", 32'(byte_if.data_valid), 32'h0);
    check("data_held_after_ack", 32'(byte_if.data), 32'h41);
    ack_byte();
    check("ack_idle_ignored", 32'(byte_if.data_valid), 32'h0);
    repeat (5) tick();

    // 4-cycle glitch: false start
    fe0 = fe_cnt;
    n0 = cyc;
    rx = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) rx = 1'b1;
      tick();
    end
    check("glitch_busy_t0p8", 32'(byte_if.busy), 32'h1);
    tick();
    check("glitch_busy_t0p9", 32'(byte_if.busy), 32'h0);
    repeat (20) tick();
    check("glitch_no_valid", 32'(byte_if.data_valid), 32'h0);
    check("glitch_no_ferr", 32'(fe_cnt - fe0), 32'd0);

    // 0x55 with stop held low 40 cycles, then 0x0F
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, -1, n0);
    rx = 1'b0;
    repeat (24) tick();
    check("brk_ferr_once", 32'(fe_cnt - fe0), 32'd1);
    check("brk_no_valid", 32'(byte_if.data_valid), 32'h0);
    check("brk_busy_held", 32'(byte_if.busy), 32'h1);
    rx = 1'b1;
    repeat (4) tick();
    check("brk_exit", 32'(byte_if.busy), 32'h0);
    repeat (4) tick();
    send_frame(8'h0F, 1'b1, -1, n0);
    check("x0f_data", 32'(byte_if.data), 32'h0F);
    check("x0f_valid", 32'(byte_if.data_valid), 32'h1);
    check("x0f_ferr", 32'(fe_cnt - fe0), 32'd1);
    ack_byte();
    repeat (4) tick();

    // 0xA5 then 0x3C back-to-back: overrun
    ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1, -1, n0);
    send_frame(8'h3C, 1'b1, -1, n0);
    check("ovr_data", 32'(byte_if.data), 32'hA5);
    check("ovr_pulse_once", 32'(ov_cnt - ov0), 32'd1);
    check("ovr_valid", 32'(byte_if.data_valid), 32'h1);
    ack_byte();
    repeat (4) tick();

    // 0x12 then 0x34 with ack in the 0x34 completion cycle
    ov0 = ov_cnt;
    send_frame(8'h12, 1'b1, -1, n0);
    send_frame(8'h34, 1'b1, 154, n0);
    check("ackload_data", 32'(byte_if.data), 32'h34);
    check("ackload_valid", 32'(byte_if.data_valid), 32'h1);
    check("ackload_no_ovr", 32'(ov_cnt - ov0), 32'd0);

    // Reset in the middle of data bit 4 of 0xFF
    rx = 1'b0;
    repeat (Cpb) tick();
    rx = 1'b1;
    repeat (4 * Cpb + Cpb / 2) tick();
    check("pre_reset_busy", 32'(byte_if.busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_data", 32'(byte_if.data), 32'h00);
    check("rst_valid", 32'(byte_if.data_valid), 32'h0);
    check("rst_busy", 32'(byte_if.busy), 32'h0);
    check("rst_pulses", 32'({byte_if.frame_error, byte_if.overrun}), 32'h0);
    repeat (3 * Cpb) tick();
    check("rst_idle_busy", 32'(byte_if.busy), 32'h0);
    send_frame(8'h81, 1'b1, -1, n0);
    check("x81_data", 32'(byte_if.data), 32'h81);
    check("x81_valid", 32'(byte_if.data_valid), 32'h1);
    check("x81_latency", 32'(rise_cyc - n0), 32'd155);

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
